nrz_bit_tx_240: RTL

NRZ serial transmitter. It is the transmit-side counterpart of the bit-sync/data-transition PLL receiver. Parallel words are buffered in a small FIFO and shifted out MSB-first at a programmable bit rate, which is set by a 32-bit phase-accumulator NCO on the 240 MHz clock. The block drives a serial data line and a companion bit clock whose rising edge sits mid-bit, so the receiver can track either the clock edges or the data transitions.

---
 rtl/nrz_bit_tx_240.sv | 130 +++++++++++++
 1 files changed

// File: rtl/nrz_bit_tx_240.sv
// NRZ serial transmitter: word FIFO, MSB-first shifter, 32-bit NCO bit clock.
// Define NRZ_M_EN for NRZ-M line coding (toggle on 1); default is NRZ-L.
module nrz_bit_tx_240 #(
    parameter int   WORD_W     = 8,
    parameter int   FIFO_DEPTH = 4,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [31:0]                   frequency_set,
    input  logic [WORD_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          data,
    output logic                          clock,
    output logic                          sym_phase_of,
    output logic [31:0]                   NCO,
    output logic                          busy,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Handshake: a word moves into the FIFO on any clk edge where din_valid and
    // din_ready are both high; din_ready depends only on the registered level.
    state_t              state;
    logic [31:0]         freq_reg;
    logic [32:0]         nco_sum;
    logic                carry;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [WORD_W-1:0]   head;
    logic [WORD_W-2:0]   shift_reg;
    logic [CW-1:0]       bit_cnt;
    logic                fifo_empty;
    logic                push;
    logic                load;
    logic                mid_word;
    logic                next_bit;
    logic                line_next;
    logic                idle_next;

    assign nco_sum    = {1'b0, NCO} + {1'b0, freq_reg};
    assign carry      = enable & nco_sum[32];
    assign fifo_empty = (fifo_level == '0);
    assign din_ready  = (fifo_level != FULL_LVL);
    assign push       = din_valid & din_ready;
    assign head       = mem[rd_ptr];
    assign mid_word   = (state == SHIFT) && (bit_cnt != LAST_BIT);
    assign load       = carry & ~fifo_empty & ~mid_word;
    assign next_bit   = mid_word ? shift_reg[WORD_W-2] : head[WORD_W-1];
    assign busy       = (state == SHIFT);

`ifdef NRZ_M_EN
    assign line_next = data ^ next_bit;
    assign idle_next = data;
`else
    assign line_next = next_bit;
    assign idle_next = IDLE_LEVEL;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            NCO          <= '0;
            freq_reg     <= '0;
            sym_phase_of <= 1'b0;
            clock        <= 1'b0;
            data         <= IDLE_LEVEL;
            underrun     <= 1'b0;
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            if (push && !load)      fifo_level <= fifo_level + 1'b1;
            else if (load && !push) fifo_level <= fifo_level - 1'b1;

            if (!enable) begin
                // Holding off drops the partial word but keeps the FIFO.
                NCO          <= '0;
                freq_reg     <= frequency_set;
                sym_phase_of <= 1'b0;
                clock        <= 1'b0;
                data         <= IDLE_LEVEL;
                underrun     <= 1'b0;
                state        <= IDLE;
                bit_cnt      <= '0;
            end else begin
                NCO          <= nco_sum[31:0];
                sym_phase_of <= carry;
                clock        <= nco_sum[31];
                if (carry) begin
                    // Rate changes land only on a bit boundary.
                    freq_reg <= frequency_set;
                    if (load) begin
                        shift_reg <= head[WORD_W-2:0];
                        data      <= line_next;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end else if (mid_word) begin
                        shift_reg <= shift_reg << 1;
                        data      <= line_next;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end else if (state == SHIFT) begin
                        data      <= idle_next;
                        state     <= IDLE;
                        underrun  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
